// File: rtl/counter_arbiter_pkg.sv
// Shared types, default sizes and the round-robin search used by the counter arbiter.
package counter_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam int N_DEF = 4;
  localparam int M_DEF = 13;

  // Scan from ptr upward, wrapping modulo n; the first set request wins (0 when none).
  function automatic int nxt_rr(input logic [15:0] req, input int ptr, input int n);
    int win;
    int j;
    bit found;
    win   = 0;
    j     = 0;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i < n && !found) begin
        j = (ptr + i) % n;
        if (req[j[3:0]]) begin
          win   = j;
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/counter_arbiter_if.sv
// Requester/counter-side bundle for counter_arbiter.
// rsp_wrap exists only when COUNTER_ARBITER_WRAP_FLAG_EN is defined.
interface counter_arbiter_if
  import counter_arbiter_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF,
  parameter int B = $clog2(M)
) ();

  logic [N-1:0] req;
  logic [N-1:0] dir;
  logic [B-1:0] cnt;
  logic         inc;
  logic         dec;
  logic [N-1:0] ack;
  logic [B-1:0] rsp_cnt;
  logic         busy;
`ifdef COUNTER_ARBITER_WRAP_FLAG_EN
  logic         rsp_wrap;

  modport master (output req, dir, cnt, input inc, dec, ack, rsp_cnt, busy, rsp_wrap);
  modport slave  (input req, dir, cnt, output inc, dec, ack, rsp_cnt, busy, rsp_wrap);
`else
  modport master (output req, dir, cnt, input inc, dec, ack, rsp_cnt, busy);
  modport slave  (input req, dir, cnt, output inc, dec, ack, rsp_cnt, busy);
`endif

endinterface

// File: rtl/counter_arbiter_rr_arbiter.sv
// Combinational round-robin picker: request vector plus priority pointer in, one-hot grant and index out.
module rr_arbiter
  import counter_arbiter_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  always_comb begin
    idx   = IW'(nxt_rr(16'(req), int'(ptr), N));
    grant = '0;
    if (|req) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin sharing of one external modulo-M up/down counter among N requesters.
// Optional rsp_wrap output is enabled by defining COUNTER_ARBITER_WRAP_FLAG_EN.
module counter_arbiter
  import counter_arbiter_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF,
  parameter int B = $clog2(M)
) (
  input  logic              clk,
  input  logic              rst,
  counter_arbiter_if.slave  bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

  localparam logic [B-1:0] CNT_MAX = B'(M - 1);

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] gnt_idx_q, gnt_idx_d;
  logic          dir_q, dir_d;
  logic          inc_q, inc_d;
  logic          dec_q, dec_d;
  logic [N-1:0]  ack_q, ack_d;
  logic [B-1:0]  rsp_cnt_q, rsp_cnt_d;
  logic          busy_q, busy_d;
`ifdef COUNTER_ARBITER_WRAP_FLAG_EN
  logic          rsp_wrap_q, rsp_wrap_d;
`endif

  logic [N-1:0]  grant;
  logic [IW-1:0] win_idx;
  logic [B-1:0]  cnt_up;
  logic [B-1:0]  cnt_down;

  rr_arbiter #(.N(N), .IW(IW)) u_rr (
    .req   (bus.req),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (win_idx)
  );

  // The counter commits the pulse on the same edge that registers ack, so the
  // response is the value the counter is about to hold, wrapped the same way.
  assign cnt_up   = (bus.cnt == CNT_MAX) ? '0 : bus.cnt + 1'b1;
  assign cnt_down = (bus.cnt == '0) ? CNT_MAX : bus.cnt - 1'b1;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_idx_d = gnt_idx_q;
    dir_d     = dir_q;
    inc_d     = 1'b0;
    dec_d     = 1'b0;
    ack_d     = '0;
    rsp_cnt_d = '0;
`ifdef COUNTER_ARBITER_WRAP_FLAG_EN
    rsp_wrap_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          gnt_idx_d = win_idx;
          dir_d     = |(bus.dir & grant);
          inc_d     = dir_d;
          dec_d     = !dir_d;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        ack_d[gnt_idx_q] = 1'b1;
        rsp_cnt_d        = dir_q ? cnt_up : cnt_down;
`ifdef COUNTER_ARBITER_WRAP_FLAG_EN
        rsp_wrap_d       = dir_q ? (bus.cnt == CNT_MAX) : (bus.cnt == '0);
`endif
        state_d          = ST_ACK;
      end
      ST_ACK: begin
        ptr_d   = (gnt_idx_q == IW'(N - 1)) ? '0 : gnt_idx_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      gnt_idx_q  <= '0;
      dir_q      <= 1'b0;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      ack_q      <= '0;
      rsp_cnt_q  <= '0;
      busy_q     <= 1'b0;
`ifdef COUNTER_ARBITER_WRAP_FLAG_EN
      rsp_wrap_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      dir_q      <= dir_d;
      inc_q      <= inc_d;
      dec_q      <= dec_d;
      ack_q      <= ack_d;
      rsp_cnt_q  <= rsp_cnt_d;
      busy_q     <= busy_d;
`ifdef COUNTER_ARBITER_WRAP_FLAG_EN
      rsp_wrap_q <= rsp_wrap_d;
`endif
    end
  end

  assign bus.inc     = inc_q;
  assign bus.dec     = dec_q;
  assign bus.ack     = ack_q;
  assign bus.rsp_cnt = rsp_cnt_q;
  assign bus.busy    = busy_q;
`ifdef COUNTER_ARBITER_WRAP_FLAG_EN
  assign bus.rsp_wrap = rsp_wrap_q;
`endif

  // The granted requester must keep req up until its ack has been seen.
  req_held_a: assert property (@(posedge clk) disable iff (!rst)
    (state_q != ST_IDLE) |-> bus.req[gnt_idx_q]);

  one_pulse_a: assert property (@(posedge clk) disable iff (!rst) !(inc_q && dec_q));

endmodule
